// File: rtl/dco_code_ctrl.sv
// dco_code_ctrl: target-code handshake, slew-limited ramp of the varactor control word, optional
//   fractional dither (compile with DCO_DITHER_EN to enable the accumulator/pointer/con_perb path).
// Latency: acceptance at edge k -> busy after k, first code step after k+1; all outputs registered.
// Backpressure: tgt_ready only in IDLE with hold low; tgt_valid must be held until accepted.
module dco_code_ctrl #(
  parameter int STEP       = 1,
  parameter int RESET_CODE = 144
) (
  input  logic       ref_clk,
  input  logic       rstb,
  input  logic [8:0] tgt_code,
  input  logic [3:0] tgt_frac,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  input  logic       hold,
  output logic       busy,
  output logic [7:0] delay_con_msb,
  output logic [4:0] delay_con_lsb,
  output logic [3:0] con_perb
);

  localparam logic [8:0] MAX_CODE = 9'd287;
  localparam logic [8:0] RST_CODE = 9'(RESET_CODE);
  localparam logic [9:0] STEP_W   = 10'(STEP);

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

  state_t      r_state;
  logic [8:0]  r_cur;
  logic [8:0]  r_tgt;
  logic        r_busy;
  logic [7:0]  r_msb;
  logic [4:0]  r_lsb;

  logic [8:0]        w_tgt_clamp;
  logic signed [9:0] w_diff;
  logic [9:0]        w_abs;
  logic [9:0]        w_step;
  logic [9:0]        w_ramp;
  logic [8:0]        w_cur_nxt;

  // Thermometer MSB word: cur/32 ones filled from bit 0 upward (0..8 ones).
  function automatic logic [7:0] f_therm(input logic [8:0] c);
    logic [8:0] t;
    t = (9'd1 << c[8:5]) - 9'd1;
    return t[7:0];
  endfunction

  assign w_tgt_clamp = (tgt_code > MAX_CODE) ? MAX_CODE : tgt_code;
  assign tgt_ready   = (r_state == IDLE) && !hold;

  // Slew-limited next code: move toward tgt by min(STEP, |tgt-cur|), never past it.
  always_comb begin
    w_diff    = $signed({1'b0, r_tgt}) - $signed({1'b0, r_cur});
    w_abs     = w_diff[9] ? 10'(-w_diff) : 10'(w_diff);
    w_step    = (w_abs < STEP_W) ? w_abs : STEP_W;
    w_ramp    = w_diff[9] ? ({1'b0, r_cur} - w_step) : ({1'b0, r_cur} + w_step);
    w_cur_nxt = r_cur;
    if (!hold && (r_state == RAMP)) begin
      w_cur_nxt = w_ramp[8:0];
    end
  end

  // Control FSM with registered code outputs; hold freezes everything.
  always_ff @(posedge ref_clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= IDLE;
      r_cur   <= RST_CODE;
      r_tgt   <= RST_CODE;
      r_busy  <= 1'b0;
      r_msb   <= f_therm(RST_CODE);
      r_lsb   <= RST_CODE[4:0];
    end else if (!hold) begin
      case (r_state)
        IDLE: begin
          if (tgt_valid) begin
            r_tgt <= w_tgt_clamp;
            if (w_tgt_clamp != r_cur) begin
              r_state <= RAMP;
              r_busy  <= 1'b1;
            end
          end
        end
        RAMP: begin
          r_cur <= w_cur_nxt;
          r_msb <= f_therm(w_cur_nxt);
          r_lsb <= w_cur_nxt[4:0];
          if (w_cur_nxt == r_tgt) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign delay_con_msb = r_msb;
  assign delay_con_lsb = r_lsb;

`ifdef DCO_DITHER_EN
  logic [3:0] r_frac;
  logic [3:0] r_acc;
  logic [1:0] r_ptr;
  logic [3:0] r_perb;
  logic [4:0] w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, r_frac};

  // First-order fractional accumulator; each carry pulses one rotating perturbation unit.
  always_ff @(posedge ref_clk or negedge rstb) begin
    if (!rstb) begin
      r_frac <= 4'd0;
      r_acc  <= 4'd0;
      r_ptr  <= 2'd0;
      r_perb <= 4'd0;
    end else if (!hold) begin
      if (r_state == IDLE) begin
        r_acc <= w_sum[3:0];
        if (w_sum[4]) begin
          r_perb <= 4'b0001 << r_ptr;
          r_ptr  <= r_ptr + 2'd1;
        end else begin
          r_perb <= 4'd0;
        end
        if (tgt_valid) begin
          r_frac <= tgt_frac;
        end
      end else begin
        r_perb <= 4'd0;
      end
    end
  end

  assign con_perb = r_perb;
`else
  logic w_unused_frac;
  assign w_unused_frac = ^tgt_frac;
  assign con_perb      = 4'd0;
`endif

endmodule

// File: tb/tb_dco_code_ctrl.sv
// Randomized + directed bench for dco_code_ctrl: a cycle model pushes expected outputs per edge,
// a monitor pops and compares them one step after the edge.
// Works with and without DCO_DITHER_EN.
module tb_dco_code_ctrl;
  localparam int STEP = 4;
  localparam int RC   = 144;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic [8:0] tgt_code = 9'd0;
  logic [3:0] tgt_frac = 4'd0;
  logic       tgt_valid = 1'b0;
  logic       tgt_ready;
  logic       hold = 1'b0;
  logic       busy;
  logic [7:0] delay_con_msb;
  logic [4:0] delay_con_lsb;
  logic [3:0] con_perb;

  int n_checks = 0;
  int n_fail   = 0;

  dco_code_ctrl #(.STEP(STEP), .RESET_CODE(RC)) dut (
    .ref_clk(clk), .rstb(rstb), .tgt_code(tgt_code), .tgt_frac(tgt_frac),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .hold(hold), .busy(busy),
    .delay_con_msb(delay_con_msb), .delay_con_lsb(delay_con_lsb), .con_perb(con_perb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int msb;
    int lsb;
    int perb;
    int busy;
  } exp_t;
  exp_t q[$];

  int m_cur = RC, m_tgt = RC, m_busy = 0, m_acc = 0, m_ptr = 0, m_frac = 0, m_perb = 0;

  function automatic int therm(input int code);
    return ((1 << (code / 32)) - 1) & 8'hFF;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int   s;
    int   d;
    if (!rstb) begin
      m_cur = RC; m_tgt = RC; m_busy = 0; m_acc = 0; m_ptr = 0; m_frac = 0; m_perb = 0;
    end else if (!hold) begin
      if (!m_busy) begin
`ifdef DCO_DITHER_EN
        s = m_acc + m_frac;
        if (s >= 16) begin
          m_perb = 1 << m_ptr;
          m_ptr  = (m_ptr + 1) % 4;
        end else begin
          m_perb = 0;
        end
        m_acc = s % 16;
`endif
        if (tgt_valid) begin
          m_tgt  = (int'(tgt_code) > 287) ? 287 : int'(tgt_code);
          m_frac = int'(tgt_frac);
          if (m_tgt != m_cur) m_busy = 1;
        end
      end else begin
        m_perb = 0;
        d = m_tgt - m_cur;
        if (d > 0) m_cur = m_cur + ((d < STEP) ? d : STEP);
        else       m_cur = m_cur - ((-d < STEP) ? -d : STEP);
        if (m_cur == m_tgt) m_busy = 0;
      end
    end
    e.msb = therm(m_cur); e.lsb = m_cur % 32; e.perb = m_perb; e.busy = m_busy;
    q.push_back(e);
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("msb",   int'(delay_con_msb), e.msb);
      check("lsb",   int'(delay_con_lsb), e.lsb);
      check("perb",  int'(con_perb),      e.perb);
      check("busy",  int'(busy),          e.busy);
      check("ready", int'(tgt_ready),     int'(!e.busy && !hold));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int code, input int frac);
    logic r;
    @(negedge clk);
    tgt_code = 9'(code); tgt_frac = 4'(frac); tgt_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #1 r = tgt_ready;
      @(negedge clk);
      if (r) begin
        tgt_valid = 1'b0;
        return;
      end
    end
    tgt_valid = 1'b0;
    check("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    check("idle_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_msb"},   int'(delay_con_msb), 8'h0F);
    check({tag, "_lsb"},   int'(delay_con_lsb), 16);
    check({tag, "_perb"},  int'(con_perb),      0);
    check({tag, "_busy"},  int'(busy),          0);
    check({tag, "_ready"}, int'(tgt_ready),     1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    #1 check_reset_outputs("rst");

    // Small move: 144 -> 150 (steps of 4, last step clipped)
    send(150, 0);
    wait_idle();
    check("t150_lsb", int'(delay_con_lsb), 22);
    check("t150_msb", int'(delay_con_msb), 8'h0F);

    // Clamp: 280, then 400 -> 287 with no overshoot
    send(280, 0);
    wait_idle();
    send(400, 0);
    wait_idle();
    check("clamp_msb", int'(delay_con_msb), 8'hFF);
    check("clamp_lsb", int'(delay_con_lsb), 31);

    // Hold mid-ramp for 3 cycles, plus ignored target pulses during RAMP
    send(100, 0);
    repeat (2) @(negedge clk);
    hold = 1'b1; tgt_valid = 1'b1; tgt_code = 9'd5;
    repeat (3) @(negedge clk);
    hold = 1'b0;
    @(negedge clk);
    tgt_valid = 1'b0;
    wait_idle();
    check("hold_final", int'(delay_con_lsb) + 32 * $countones(delay_con_msb), 100);

    // Dither: same code keeps IDLE, frac latched
    send(100, 4);
    repeat (20) @(negedge clk);
    send(100, 11);
    repeat (20) @(negedge clk);
    send(100, 0);
    repeat (8) @(negedge clk);

    // Reset mid-ramp at cur=200
    send(280, 0);
    for (int i = 0; i < 100 && m_cur != 200; i++) @(negedge clk);
    check("reach200", m_cur, 200);
    rstb = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rstb = 1'b1;
    #1 check_reset_outputs("postrst");

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      hold      = ($urandom_range(0, 7) == 0);
      tgt_valid = ($urandom_range(0, 5) == 0);
      tgt_code  = 9'($urandom_range(0, 511));
      tgt_frac  = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    hold = 1'b0; tgt_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
